// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: reprograms the integer divider of one MMCM output over DRP.
// Holds the MMCM in reset, read-modify-writes the two clock-output registers,
// releases reset and waits for LOCKED.
// Optional lock watchdog: define MMCM_DRP_LOCK_TIMEOUT_EN.
module mmcm_drp_reconfig #(
    parameter int unsigned DRDY_TIMEOUT = 255,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        CLKIN1,
    input  logic        RST_N,
    input  logic        START,
    input  logic [2:0]  OUT_SEL,
    input  logic [6:0]  DIVIDE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic        MMCM_RST,
    input  logic        LOCKED
);

    localparam int unsigned MAX_TO = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned CW     = $clog2(MAX_TO + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ASSERT_RST,
        S_RD1,
        S_WAIT_RD1,
        S_WR1,
        S_WAIT_WR1,
        S_RD2,
        S_WAIT_RD2,
        S_WR2,
        S_WAIT_WR2,
        S_RELEASE,
        S_WAIT_LOCK
    } state_t;

    state_t          r_state;
    logic [2:0]      r_sel;
    logic [6:0]      r_div;
    logic [CW-1:0]   r_cnt;

    logic            w_legal;
    logic [6:0]      w_addr1;
    logic [6:0]      w_addr2;
    logic            w_div1;
    logic [5:0]      w_high;
    logic [5:0]      w_low;
    logic            w_edge;
    logic            w_nocount;
    logic            w_drdy_to;

    assign w_legal   = (OUT_SEL != 3'd7) && (DIVIDE != 7'd0) && (DIVIDE != 7'd127);

    // DIVIDE=1 is a bypassed counter: fixed 1/1 counts with NO_COUNT set.
    assign w_div1    = (r_div == 7'd1);
    assign w_high    = w_div1 ? 6'd1 : r_div[6:1];
    assign w_low     = w_div1 ? 6'd1 : r_div[6:1] + {5'd0, r_div[0]};
    assign w_edge    = w_div1 ? 1'b0 : r_div[0];
    assign w_nocount = w_div1;

    assign w_addr2   = w_addr1 + 7'd1;
    assign w_drdy_to = (r_cnt == CW'(DRDY_TIMEOUT - 1));

`ifdef MMCM_DRP_LOCK_TIMEOUT_EN
    logic w_lock_to;
    assign w_lock_to = (r_cnt == CW'(LOCK_TIMEOUT - 1));
`endif

    // Map the latched output select to its first (REG1) DRP address.
    always_comb begin
        w_addr1 = 7'h12;
        case (r_sel)
            3'd0:    w_addr1 = 7'h08;
            3'd1:    w_addr1 = 7'h0A;
            3'd2:    w_addr1 = 7'h0C;
            3'd3:    w_addr1 = 7'h0E;
            3'd4:    w_addr1 = 7'h10;
            3'd5:    w_addr1 = 7'h06;
            default: w_addr1 = 7'h12;
        endcase
    end

    // Reconfiguration sequencer with registered DRP, reset and status outputs.
    always_ff @(posedge CLKIN1 or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            DADDR    <= '0;
            DEN      <= 1'b0;
            DWE      <= 1'b0;
            DI       <= '0;
            MMCM_RST <= 1'b0;
        end else begin
            DEN  <= 1'b0;
            DWE  <= 1'b0;
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (START) begin
                        if (w_legal) begin
                            r_sel    <= OUT_SEL;
                            r_div    <= DIVIDE;
                            BUSY     <= 1'b1;
                            MMCM_RST <= 1'b1;
                            r_state  <= S_ASSERT_RST;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                S_ASSERT_RST: begin
                    DEN     <= 1'b1;
                    DADDR   <= w_addr1;
                    r_state <= S_RD1;
                end
                S_RD1: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_RD1;
                end
                S_WR1: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_WR1;
                end
                S_RD2: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_RD2;
                end
                S_WR2: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_WR2;
                end
                // All four DRP waits share the DRDY watchdog; only the next access differs.
                S_WAIT_RD1, S_WAIT_WR1, S_WAIT_RD2, S_WAIT_WR2: begin
                    if (DRDY) begin
                        r_cnt <= '0;
                        case (r_state)
                            S_WAIT_RD1: begin
                                DEN     <= 1'b1;
                                DWE     <= 1'b1;
                                DADDR   <= w_addr1;
                                DI      <= (DO & 16'hF000) | {4'h0, w_high, w_low};
                                r_state <= S_WR1;
                            end
                            S_WAIT_WR1: begin
                                DEN     <= 1'b1;
                                DADDR   <= w_addr2;
                                r_state <= S_RD2;
                            end
                            S_WAIT_RD2: begin
                                DEN     <= 1'b1;
                                DWE     <= 1'b1;
                                DADDR   <= w_addr2;
                                DI      <= (DO & 16'hFF3F) | {8'h00, w_edge, w_nocount, 6'h00};
                                r_state <= S_WR2;
                            end
                            default: begin
                                MMCM_RST <= 1'b0;
                                r_state  <= S_RELEASE;
                            end
                        endcase
                    end else if (w_drdy_to) begin
                        r_cnt    <= '0;
                        ERR      <= 1'b1;
                        BUSY     <= 1'b0;
                        MMCM_RST <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (LOCKED) begin
                        r_cnt   <= '0;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        r_state <= S_IDLE;
                    end
`ifdef MMCM_DRP_LOCK_TIMEOUT_EN
                    else if (w_lock_to) begin
                        r_cnt   <= '0;
                        ERR     <= 1'b1;
                        BUSY    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end
                default: begin
                    r_cnt    <= '0;
                    BUSY     <= 1'b0;
                    MMCM_RST <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// tb_mmcm_drp_reconfig: scoreboard bench with a DRP register-file responder
// and a simple MMCM lock model.
module tb_mmcm_drp_reconfig;

    localparam int unsigned DRDY_TO = 40;
    localparam int unsigned LOCK_TO = 200;

    logic        CLKIN1 = 1'b0;
    logic        RST_N  = 1'b1;
    logic        START  = 1'b0;
    logic [2:0]  OUT_SEL = '0;
    logic [6:0]  DIVIDE  = '0;
    logic        BUSY, DONE, ERR, DEN, DWE, MMCM_RST;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO     = '0;
    logic        DRDY   = 1'b0;
    logic        LOCKED = 1'b1;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
    } drp_t;

    drp_t        exp_q[$];
    logic [15:0] mem [0:127];
    int          n_vec = 0;
    int          n_bad = 0;
    int          den_count = 0;

    int          rsp_lat = 2;
    bit          withhold = 1'b0;
    bit          lock_block = 1'b0;
    int          lock_dly = 3;
    int          lock_cnt = 0;
    bit          pend = 1'b0;
    bit          outstanding = 1'b0;
    logic        pend_we;
    logic [6:0]  pend_addr;
    logic [15:0] pend_data;
    int          pend_cnt = 0;

    mmcm_drp_reconfig #(
        .DRDY_TIMEOUT(DRDY_TO),
        .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .CLKIN1  (CLKIN1),
        .RST_N   (RST_N),
        .START   (START),
        .OUT_SEL (OUT_SEL),
        .DIVIDE  (DIVIDE),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR),
        .DADDR   (DADDR),
        .DEN     (DEN),
        .DWE     (DWE),
        .DI      (DI),
        .DO      (DO),
        .DRDY    (DRDY),
        .MMCM_RST(MMCM_RST),
        .LOCKED  (LOCKED)
    );

    always #5 CLKIN1 = ~CLKIN1;

    // DRP responder, access scoreboard and lock model, all on the falling edge.
    always @(negedge CLKIN1) begin
        drp_t e;
        DRDY = 1'b0;
        if (!RST_N || !BUSY) outstanding = 1'b0;
        if (!RST_N) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (pend_cnt <= 1) begin
                    DRDY = 1'b1;
                    if (pend_we) mem[pend_addr] = pend_data;
                    else         DO = mem[pend_addr];
                    pend = 1'b0;
                    outstanding = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (DEN) begin
                den_count++;
                n_vec++;
                if (outstanding) begin
                    n_bad++;
                    $display("FAIL drp_overlap: DEN at addr %h while previous access unanswered, required no DEN", DADDR);
                end
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL drp_unexpected: got we=%0b addr=%h di=%h, required no access", DWE, DADDR, DI);
                end else begin
                    e = exp_q.pop_front();
                    if (DWE !== e.we || DADDR !== e.addr || (e.we && DI !== e.data) || MMCM_RST !== 1'b1) begin
                        n_bad++;
                        $display("FAIL drp_access: got we=%0b addr=%h di=%h rst=%0b, required we=%0b addr=%h di=%h rst=1",
                                 DWE, DADDR, DI, MMCM_RST, e.we, e.addr, e.data);
                    end
                end
                outstanding = 1'b1;
                if (!withhold) begin
                    pend      = 1'b1;
                    pend_we   = DWE;
                    pend_addr = DADDR;
                    pend_data = DI;
                    pend_cnt  = rsp_lat;
                end
            end
        end
        if (DONE === 1'b1 || ERR === 1'b1) begin
            n_vec++;
            if (DONE === 1'b1 && ERR === 1'b1) begin
                n_bad++;
                $display("FAIL done_err_excl: got DONE=1 ERR=1, required only one");
            end
        end
        if (MMCM_RST === 1'b1) begin
            LOCKED   = 1'b0;
            lock_cnt = lock_dly;
        end else if (!LOCKED && !lock_block) begin
            if (lock_cnt <= 1) LOCKED = 1'b1;
            else               lock_cnt--;
        end
    end

    task automatic tick();
        @(posedge CLKIN1);
        #1;
    endtask

    task automatic start_req(input logic [2:0] s, input logic [6:0] d);
        START   = 1'b1;
        OUT_SEL = s;
        DIVIDE  = d;
        tick();
        START   = 1'b0;
    endtask

    // Expected DRP traffic for one legal request, from the current register file.
    function automatic void push_txn(input logic [2:0] s, input logic [6:0] d);
        drp_t        t;
        logic [6:0]  a1;
        int          hi, lo;
        logic        edg, nc;
        logic [15:0] r1, r2;
        case (s)
            3'd0:    a1 = 7'h08;
            3'd1:    a1 = 7'h0A;
            3'd2:    a1 = 7'h0C;
            3'd3:    a1 = 7'h0E;
            3'd4:    a1 = 7'h10;
            3'd5:    a1 = 7'h06;
            default: a1 = 7'h12;
        endcase
        if (d == 7'd1) begin
            hi = 1; lo = 1; edg = 1'b0; nc = 1'b1;
        end else begin
            hi = int'(d) / 2; lo = int'(d) - hi; edg = d[0]; nc = 1'b0;
        end
        r1 = mem[a1];
        r2 = mem[a1 + 7'd1];
        t.we = 1'b0; t.addr = a1;         t.data = '0;                                    exp_q.push_back(t);
        t.we = 1'b1; t.addr = a1;         t.data = {r1[15:12], 6'(hi), 6'(lo)};           exp_q.push_back(t);
        t.we = 1'b0; t.addr = a1 + 7'd1;  t.data = '0;                                    exp_q.push_back(t);
        t.we = 1'b1; t.addr = a1 + 7'd1;  t.data = {r2[15:8], edg, nc, r2[5:0]};          exp_q.push_back(t);
    endfunction

    task automatic wait_end(input int budget, output bit got_done, output bit got_err, output bit timed_out);
        got_done  = 1'b0;
        got_err   = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (DONE === 1'b1 || ERR === 1'b1) begin
                got_done  = DONE;
                got_err   = ERR;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 RST_N = 1'b0;
        repeat (3) @(posedge CLKIN1);
        #1;
        n_vec++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0 || MMCM_RST !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_status: got busy=%b done=%b err=%b rst=%b, required 0 0 0 0", BUSY, DONE, ERR, MMCM_RST);
        end
        n_vec++;
        if (DEN !== 1'b0 || DWE !== 1'b0 || DADDR !== 7'h00 || DI !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_drp: got den=%b dwe=%b daddr=%h di=%h, required 0 0 00 0000", DEN, DWE, DADDR, DI);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_div7();
        bit d_, e_, to_;
        mem[7'h0C] = 16'hE000;
        mem[7'h0D] = 16'h0000;
        push_txn(3'd2, 7'd7);
        start_req(3'd2, 7'd7);
        n_vec++;
        if (BUSY !== 1'b1 || MMCM_RST !== 1'b1) begin
            n_bad++;
            $display("FAIL div7_accept: got busy=%b rst=%b, required 1 1", BUSY, MMCM_RST);
        end
        wait_end(400, d_, e_, to_);
        n_vec++;
        if (to_ || d_ !== 1'b1 || e_ !== 1'b0) begin
            n_bad++;
            $display("FAIL div7_done: got done=%b err=%b timeout=%b, required 1 0 0", d_, e_, to_);
        end
        n_vec++;
        if (mem[7'h0C] !== 16'hE0C4 || mem[7'h0D] !== 16'h0080) begin
            n_bad++;
            $display("FAIL div7_regs: got 0C=%h 0D=%h, required E0C4 0080", mem[7'h0C], mem[7'h0D]);
        end
        n_vec++;
        if (BUSY !== 1'b0 || MMCM_RST !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL div7_idle: got busy=%b rst=%b pending=%0d, required 0 0 0", BUSY, MMCM_RST, exp_q.size());
        end
        tick();
        n_vec++;
        if (DONE !== 1'b0) begin
            n_bad++;
            $display("FAIL div7_pulse: got DONE=%b one cycle later, required 0", DONE);
        end
    endtask

    task automatic test_div1();
        bit d_, e_, to_;
        mem[7'h06] = 16'hABCD;
        mem[7'h07] = 16'h1234;
        push_txn(3'd5, 7'd1);
        start_req(3'd5, 7'd1);
        // Inputs change and START re-pulses while busy; neither may affect the run.
        START = 1'b1; OUT_SEL = 3'd3; DIVIDE = 7'd50;
        repeat (3) tick();
        START = 1'b0;
        wait_end(400, d_, e_, to_);
        n_vec++;
        if (to_ || d_ !== 1'b1 || e_ !== 1'b0) begin
            n_bad++;
            $display("FAIL div1_done: got done=%b err=%b timeout=%b, required 1 0 0", d_, e_, to_);
        end
        n_vec++;
        if (mem[7'h06] !== 16'hA041 || mem[7'h07] !== 16'h1274) begin
            n_bad++;
            $display("FAIL div1_regs: got 06=%h 07=%h, required A041 1274", mem[7'h06], mem[7'h07]);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] sels [3] = '{3'd0, 3'd7, 3'd3};
        logic [6:0] divs [3] = '{7'd127, 7'd5, 7'd0};
        int den0;
        for (int i = 0; i < 3; i++) begin
            den0 = den_count;
            start_req(sels[i], divs[i]);
            n_vec++;
            if (ERR !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_err[%0d]: got err=%b busy=%b done=%b, required 1 0 0", i, ERR, BUSY, DONE);
            end
            tick();
            n_vec++;
            if (ERR !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_pulse[%0d]: got ERR=%b, required 0", i, ERR);
            end
            repeat (4) tick();
            n_vec++;
            if (den_count != den0 || MMCM_RST !== 1'b0 || BUSY !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_quiet[%0d]: got dens=%0d rst=%b busy=%b, required 0 0 0", i, den_count - den0, MMCM_RST, BUSY);
            end
        end
    endtask

    task automatic test_drdy_timeout();
        drp_t t;
        int   den0;
        bit   early;
        bit   seen;
        t.we = 1'b0; t.addr = 7'h0E; t.data = '0;
        exp_q.push_back(t);
        withhold = 1'b1;
        den0 = den_count;
        seen = 1'b0;
        start_req(3'd3, 7'd9);
        for (int i = 0; i < 20; i++) begin
            if (den_count != den0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL to_read_issued: got no DEN within 20 cycles, required a read");
        end
        early = 1'b0;
        for (int k = 1; k < int'(DRDY_TO); k++) begin
            tick();
            if (ERR === 1'b1 || DONE === 1'b1) early = 1'b1;
        end
        tick();
        n_vec++;
        if (early || ERR !== 1'b1) begin
            n_bad++;
            $display("FAIL to_err_timing: got early=%b err=%b at cycle %0d, required early=0 err=1", early, ERR, DRDY_TO);
        end
        n_vec++;
        if (MMCM_RST !== 1'b0 || BUSY !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL to_idle: got rst=%b busy=%b pending=%0d, required 0 0 0", MMCM_RST, BUSY, exp_q.size());
        end
        withhold = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        bit d_, e_, to_;
        int den0;
        bit seen;
        mem[7'h08] = 16'h1111;
        mem[7'h09] = 16'h2222;
        mem[7'h0E] = 16'h5FFF;
        mem[7'h0F] = 16'hFFFF;
        rsp_lat = 6;
        den0 = den_count;
        seen = 1'b0;
        push_txn(3'd0, 7'd10);
        start_req(3'd0, 7'd10);
        for (int i = 0; i < 40; i++) begin
            if (den_count == den0 + 2) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL rstmid_reach: got %0d accesses, required 2 before reset", den_count - den0);
        end
        #2 RST_N = 1'b0;
        #1;
        n_vec++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0 || DEN !== 1'b0 || DWE !== 1'b0 ||
            DADDR !== 7'h00 || DI !== 16'h0000 || MMCM_RST !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got busy=%b done=%b err=%b den=%b dwe=%b daddr=%h di=%h rst=%b, required all 0",
                     BUSY, DONE, ERR, DEN, DWE, DADDR, DI, MMCM_RST);
        end
        exp_q.delete();
        rsp_lat = 2;
        @(posedge CLKIN1);
        #1;
        push_txn(3'd3, 7'd4);
        RST_N = 1'b1;
        START = 1'b1; OUT_SEL = 3'd3; DIVIDE = 7'd4;
        tick();
        START = 1'b0;
        n_vec++;
        if (BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_first_edge: got busy=%b after first edge, required 1", BUSY);
        end
        wait_end(400, d_, e_, to_);
        n_vec++;
        if (to_ || d_ !== 1'b1 || mem[7'h0E] !== 16'h5082 || mem[7'h0F] !== 16'hFF3F) begin
            n_bad++;
            $display("FAIL rstmid_resume: got done=%b timeout=%b 0E=%h 0F=%h, required 1 0 5082 FF3F", d_, to_, mem[7'h0E], mem[7'h0F]);
        end
    endtask

    task automatic test_back_to_back();
        bit d_, e_, to_;
        mem[7'h0A] = 16'h0F0F;
        mem[7'h0B] = 16'hF0F0;
        mem[7'h12] = 16'h1234;
        mem[7'h13] = 16'hABCD;
        push_txn(3'd1, 7'd126);
        start_req(3'd1, 7'd126);
        wait_end(400, d_, e_, to_);
        n_vec++;
        if (to_ || d_ !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first: got done=%b timeout=%b, required 1 0", d_, to_);
        end
        push_txn(3'd6, 7'd2);
        start_req(3'd6, 7'd2);
        n_vec++;
        if (BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: got busy=%b, required 1", BUSY);
        end
        wait_end(400, d_, e_, to_);
        n_vec++;
        if (to_ || d_ !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second: got done=%b timeout=%b, required 1 0", d_, to_);
        end
        n_vec++;
        if (mem[7'h0A] !== 16'h0FFF || mem[7'h0B] !== 16'hF030 || mem[7'h12] !== 16'h1041 || mem[7'h13] !== 16'hAB0D) begin
            n_bad++;
            $display("FAIL b2b_regs: got 0A=%h 0B=%h 12=%h 13=%h, required 0FFF F030 1041 AB0D",
                     mem[7'h0A], mem[7'h0B], mem[7'h12], mem[7'h13]);
        end
    endtask

    task automatic test_lock();
        bit seen;
        bit bad;
        lock_block = 1'b1;
        push_txn(3'd4, 7'd5);
        start_req(3'd4, 7'd5);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (MMCM_RST === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL lock_release: got released=%b pending=%0d, required 1 0", seen, exp_q.size());
        end
        bad = 1'b0;
`ifdef MMCM_DRP_LOCK_TIMEOUT_EN
        for (int k = 0; k < int'(LOCK_TO); k++) begin
            tick();
            if (ERR === 1'b1 || DONE === 1'b1) bad = 1'b1;
        end
        tick();
        n_vec++;
        if (bad || ERR !== 1'b1 || BUSY !== 1'b0 || MMCM_RST !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_watchdog: got early=%b err=%b busy=%b rst=%b, required 0 1 0 0", bad, ERR, BUSY, MMCM_RST);
        end
`else
        for (int k = 0; k < 2 * int'(LOCK_TO); k++) begin
            tick();
            if (BUSY !== 1'b1 || ERR === 1'b1 || DONE === 1'b1) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL lock_wait_forever: got BUSY drop or DONE/ERR within %0d cycles, required BUSY held", 2 * LOCK_TO);
        end
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
`endif
        lock_block = 1'b0;
        repeat (2) tick();
        n_vec++;
        if (BUSY !== 1'b0 || mem[7'h10] !== {mem[7'h10][15:12], 12'h083} ) begin
            n_bad++;
            $display("FAIL lock_end: got busy=%b 10=%h, required busy=0 low bits 083", BUSY, mem[7'h10]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'hA5A5 ^ 16'(i * 3);
        test_reset();
        test_div7();
        test_div1();
        test_illegal();
        test_drdy_timeout();
        test_reset_mid();
        test_back_to_back();
        test_lock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
